// File: rtl/mem_stage_if.sv
// Handshake and data-bus bundle for mem_stage: execute-side input, data bus
// request/response and writeback output. master = the stage, slave = its surroundings.
interface mem_stage_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RD_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_op;
  logic [XLEN-1:0] in_addr;
  logic [XLEN-1:0] in_wdata;
  logic [RD_W-1:0] in_rd;

  logic            dreq_valid;
  logic            dreq_ready;
  logic            dreq_write;
  logic [XLEN-1:0] dreq_addr;
  logic [7:0]      dreq_strb;
  logic [XLEN-1:0] dreq_wdata;

  logic            dresp_valid;
  logic [XLEN-1:0] dresp_rdata;

  logic            out_valid;
  logic            out_ready;
  logic [RD_W-1:0] out_rd;
  logic [XLEN-1:0] out_data;
  logic            out_wen;
  logic            out_exc;

  modport master (
    input  in_valid, in_op, in_addr, in_wdata, in_rd,
    output in_ready,
    output dreq_valid, dreq_write, dreq_addr, dreq_strb, dreq_wdata,
    input  dreq_ready,
    input  dresp_valid, dresp_rdata,
    output out_valid, out_rd, out_data, out_wen, out_exc,
    input  out_ready
  );

  modport slave (
    output in_valid, in_op, in_addr, in_wdata, in_rd,
    input  in_ready,
    input  dreq_valid, dreq_write, dreq_addr, dreq_strb, dreq_wdata,
    output dreq_ready,
    output dresp_valid, dresp_rdata,
    input  out_valid, out_rd, out_data, out_wen, out_exc,
    output out_ready
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: one load/store at a time on a valid/ready bus, load alignment
// and extension, writeback handshake. MEM_MISALIGN_CHECK_EN enables misalignment traps.
module mem_stage #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RD_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_stage_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [4:0]      op_q, op_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            exc_q, exc_d;

  logic [XLEN-1:0] size_mask;
  logic [5:0]      lane_sh;
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_data;
  logic            ld_sext;
  logic [7:0]      strb_base;
`ifdef MEM_MISALIGN_CHECK_EN
  logic            misaligned;
  assign misaligned = |(bus.in_addr & size_mask);
`endif

  assign size_mask = (XLEN'(1) << bus.in_op[1:0]) - XLEN'(1);
  assign lane_sh   = {addr_q[2:0], 3'b000};
  assign ld_shift  = bus.dresp_rdata >> lane_sh;
  assign ld_sext   = !op_q[2] || (op_q[1:0] == 2'd3);

  always_comb begin
    ld_data   = ld_shift;
    strb_base = 8'hFF;
    case (op_q[1:0])
      2'd0: begin
        ld_data   = {{(XLEN-8){ld_sext & ld_shift[7]}}, ld_shift[7:0]};
        strb_base = 8'h01;
      end
      2'd1: begin
        ld_data   = {{(XLEN-16){ld_sext & ld_shift[15]}}, ld_shift[15:0]};
        strb_base = 8'h03;
      end
      2'd2: begin
        ld_data   = {{(XLEN-32){ld_sext & ld_shift[31]}}, ld_shift[31:0]};
        strb_base = 8'h0F;
      end
      default: begin
        ld_data   = ld_shift;
        strb_base = 8'hFF;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    rd_d    = rd_q;
    exc_d   = exc_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.in_op;
          addr_d  = bus.in_addr;
          wdata_d = bus.in_wdata;
          rd_d    = bus.in_rd;
          exc_d   = 1'b0;
          if (!bus.in_op[4]) begin
            data_d  = bus.in_addr;
            state_d = S_DONE;
          end else begin
`ifdef MEM_MISALIGN_CHECK_EN
            if (misaligned) begin
              exc_d   = 1'b1;
              data_d  = bus.in_addr;
              state_d = S_DONE;
            end else begin
              state_d = S_REQ;
            end
`else
            // Misaligned accesses silently round down to the natural boundary.
            addr_d  = bus.in_addr & ~size_mask;
            state_d = S_REQ;
`endif
          end
        end
      end
      S_REQ: begin
        if (bus.dreq_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.dresp_valid) begin
          data_d  = op_q[3] ? '0 : ld_data;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      exc_q   <= exc_d;
    end
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.dreq_valid = (state_q == S_REQ);
  assign bus.dreq_write = op_q[3];
  assign bus.dreq_addr  = addr_q;
  assign bus.dreq_strb  = (state_q == S_REQ) ? (strb_base << addr_q[2:0]) : '0;
  assign bus.dreq_wdata = wdata_q << lane_sh;
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.out_rd     = rd_q;
  assign bus.out_data   = data_q;
`ifdef MEM_MISALIGN_CHECK_EN
  assign bus.out_exc    = exc_q;
`else
  assign bus.out_exc    = 1'b0;
`endif
  assign bus.out_wen    = !(op_q[4] & op_q[3]) & !exc_q & (rd_q != '0);
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, random transactions against a byte-level
// reference model, and asynchronous-reset sequences. Honours MEM_MISALIGN_CHECK_EN.
module tb_mem_stage;
  localparam int unsigned XLEN = 64;
  localparam int unsigned RD_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if #(.XLEN(XLEN), .RD_W(RD_W)) bus ();
  mem_stage #(.XLEN(XLEN), .RD_W(RD_W)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        has_req;
    logic        write;
    logic [63:0] addr;
    logic [7:0]  strb;
    logic [63:0] dwdata;
    logic [63:0] data;
    logic        wen;
    logic        exc;
  } exp_t;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic [63:0] rdata;
    int          req_stall;
    int          out_stall;
    exp_t        e;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
  endtask

  function automatic exp_t mk_e(input logic has_req, input logic write, input logic [63:0] addr,
                                input logic [7:0] strb, input logic [63:0] dwdata,
                                input logic [63:0] data, input logic wen, input logic exc);
    exp_t e;
    e.has_req = has_req; e.write = write; e.addr = addr; e.strb = strb;
    e.dwdata = dwdata; e.data = data; e.wen = wen; e.exc = exc;
    return e;
  endfunction

  function automatic vec_t mk_v(input string name, input logic [4:0] op, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [4:0] rd,
                                input logic [63:0] rdata, input int req_stall,
                                input int out_stall, input exp_t e);
    vec_t v;
    v.name = name; v.op = op; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.rdata = rdata; v.req_stall = req_stall; v.out_stall = out_stall; v.e = e;
    return v;
  endfunction

  // Reference: pick the access bytes one at a time and fill the upper bytes by sign rule.
  function automatic exp_t model(input logic [4:0] op, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [4:0] rd,
                                 input logic [63:0] rdata);
    exp_t e;
    int unsigned n, lane;
    logic [63:0] ea;
    logic        sbit;
    n = 1 << op[1:0];
    e = mk_e(1'b0, op[3], addr, 8'h00, 64'h0, 64'h0, 1'b0, 1'b0);
    if (!op[4]) begin
      e.data = addr;
      e.wen  = (rd != 0);
      return e;
    end
    ea = addr;
    if ((addr % 64'(n)) != 0) begin
`ifdef MEM_MISALIGN_CHECK_EN
      e.exc  = 1'b1;
      e.data = addr;
      return e;
`else
      ea = addr - (addr % 64'(n));
`endif
    end
    lane = ea[2:0];
    e.has_req = 1'b1;
    e.addr    = ea;
    for (int unsigned i = 0; i < n; i++) e.strb[lane + i] = 1'b1;
    e.dwdata = wdata << (8 * lane);
    if (op[3]) return e;
    sbit = rdata[8 * (lane + n) - 1] && (!op[2] || n == 8);
    for (int unsigned i = 0; i < 8; i++)
      e.data[8*i +: 8] = (i < n) ? rdata[8*(lane+i) +: 8] : (sbit ? 8'hFF : 8'h00);
    e.wen = (rd != 0);
    return e;
  endfunction

  task automatic run_txn(input vec_t v);
    logic [63:0] r64;
    check({v.name, ".in_ready_idle"}, bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_op = v.op; bus.in_addr = v.addr;
    bus.in_wdata = v.wdata; bus.in_rd = v.rd;
    bus.out_ready = 1'b0; bus.dreq_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_op = 5'($urandom); bus.in_addr = {$urandom, $urandom};
    bus.in_wdata = {$urandom, $urandom}; bus.in_rd = 5'($urandom);
    check({v.name, ".dreq_valid"}, bus.dreq_valid, v.e.has_req);
    if (v.e.has_req) begin
      for (int k = 0; k <= v.req_stall; k++) begin
        if (k > 0) begin
          bus.dresp_valid = (k == 1); r64 = {$urandom, $urandom}; bus.dresp_rdata = r64;
          @(negedge clk);
          bus.dresp_valid = 1'b0;
          check({v.name, ".dreq_valid_held"}, bus.dreq_valid, 1);
        end
        check({v.name, ".dreq_write"}, bus.dreq_write, v.e.write);
        check({v.name, ".dreq_addr"}, bus.dreq_addr, v.e.addr);
        check({v.name, ".dreq_strb"}, bus.dreq_strb, v.e.strb);
        check({v.name, ".dreq_wdata"}, bus.dreq_wdata, v.e.dwdata);
        check({v.name, ".in_ready_busy"}, bus.in_ready, 0);
      end
      bus.dreq_ready = 1'b1;
      @(negedge clk);
      bus.dreq_ready = 1'b0;
      check({v.name, ".dreq_dropped"}, bus.dreq_valid, 0);
      check({v.name, ".out_valid_wait"}, bus.out_valid, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.dresp_valid = 1'b1; bus.dresp_rdata = v.rdata;
      @(negedge clk);
      bus.dresp_valid = 1'b0; bus.dresp_rdata = {$urandom, $urandom};
    end
    for (int k = 0; k <= v.out_stall; k++) begin
      if (k > 0) begin
        bus.dresp_valid = (k == 1);
        @(negedge clk);
        bus.dresp_valid = 1'b0;
      end
      check({v.name, ".out_valid"}, bus.out_valid, 1);
      check({v.name, ".out_data"}, bus.out_data, v.e.data);
      check({v.name, ".out_wen"}, bus.out_wen, v.e.wen);
      check({v.name, ".out_exc"}, bus.out_exc, v.e.exc);
      check({v.name, ".out_rd"}, bus.out_rd, v.rd);
      check({v.name, ".in_ready_done"}, bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({v.name, ".out_valid_clear"}, bus.out_valid, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".in_ready"}, bus.in_ready, 1);
    check({tag, ".dreq_valid"}, bus.dreq_valid, 0);
    check({tag, ".out_valid"}, bus.out_valid, 0);
    check({tag, ".out_data"}, bus.out_data, 0);
    check({tag, ".out_wen"}, bus.out_wen, 0);
    check({tag, ".dreq_strb"}, bus.dreq_strb, 0);
  endtask

  // phase 0: reset during REQ, 1: during WAIT, 2: during DONE
  task automatic reset_during(input int phase, input string tag);
    bus.in_valid = 1'b1; bus.in_op = 5'b10011; bus.in_addr = 64'h7000;
    bus.in_wdata = 64'h0; bus.in_rd = 5'd9; bus.out_ready = 1'b0; bus.dreq_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, ".pre_dreq"}, bus.dreq_valid, 1);
    if (phase >= 1) begin
      bus.dreq_ready = 1'b1; @(negedge clk); bus.dreq_ready = 1'b0;
    end
    if (phase == 2) begin
      bus.dresp_valid = 1'b1; bus.dresp_rdata = 64'hCAFE;
      @(negedge clk);
      bus.dresp_valid = 1'b0;
      check({tag, ".pre_out_valid"}, bus.out_valid, 1);
    end
    #2 rst_n = 1'b0;
    #1 check_idle_outputs({tag, ".async"});
    @(negedge clk);
    rst_n = 1'b1;
    bus.dresp_valid = 1'b1; bus.dresp_rdata = {$urandom, $urandom};
    @(negedge clk);
    bus.dresp_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs({tag, ".stray"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vq[$];
    vec_t v;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_addr = '0; bus.in_wdata = '0; bus.in_rd = '0;
    bus.dreq_ready = 1'b0; bus.dresp_valid = 1'b0; bus.dresp_rdata = '0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset.out_exc", bus.out_exc, 0);
    check("reset.out_rd", bus.out_rd, 0);
    check("reset.dreq_addr", bus.dreq_addr, 0);
    check("reset.dreq_wdata", bus.dreq_wdata, 0);
    check("reset.dreq_write", bus.dreq_write, 0);
    rst_n = 1'b1;
    @(negedge clk);

    vq.push_back(mk_v("alu", 5'b00000, 64'h1234, 64'h0, 5'd5, 64'h0, 0, 0,
                      mk_e(0, 0, 0, 0, 0, 64'h1234, 1, 0)));
    vq.push_back(mk_v("alu_rd0", 5'b01011, 64'hFEDC, 64'h0, 5'd0, 64'h0, 0, 1,
                      mk_e(0, 0, 0, 0, 0, 64'hFEDC, 0, 0)));
    vq.push_back(mk_v("lb", 5'b10000, 64'h1003, 64'h0, 5'd7, 64'h0000_0000_8000_0000, 0, 0,
                      mk_e(1, 0, 64'h1003, 8'h08, 0, 64'hFFFF_FFFF_FFFF_FF80, 1, 0)));
    vq.push_back(mk_v("lbu", 5'b10100, 64'h1003, 64'h0, 5'd7, 64'h0000_0000_8000_0000, 0, 0,
                      mk_e(1, 0, 64'h1003, 8'h08, 0, 64'h80, 1, 0)));
    vq.push_back(mk_v("sw", 5'b11010, 64'h2004, 64'hDEADBEEF, 5'd3, 64'h0, 3, 0,
                      mk_e(1, 1, 64'h2004, 8'hF0, 64'hDEADBEEF_00000000, 0, 0, 0)));
    vq.push_back(mk_v("ld_bp", 5'b10011, 64'h3000, 64'h0, 5'd8, 64'h0123_4567_89AB_CDEF, 0, 4,
                      mk_e(1, 0, 64'h3000, 8'hFF, 0, 64'h0123_4567_89AB_CDEF, 1, 0)));
    vq.push_back(mk_v("lh", 5'b10001, 64'h4006, 64'h0, 5'd1, 64'hF00D_0000_0000_0000, 0, 0,
                      mk_e(1, 0, 64'h4006, 8'hC0, 0, 64'hFFFF_FFFF_FFFF_F00D, 1, 0)));
    vq.push_back(mk_v("lwu", 5'b10110, 64'h4004, 64'h0, 5'd2, 64'h8765_4321_0000_0000, 0, 0,
                      mk_e(1, 0, 64'h4004, 8'hF0, 0, 64'h8765_4321, 1, 0)));
    vq.push_back(mk_v("lw", 5'b10010, 64'h4004, 64'h0, 5'd2, 64'h8765_4321_0000_0000, 1, 0,
                      mk_e(1, 0, 64'h4004, 8'hF0, 0, 64'hFFFF_FFFF_8765_4321, 1, 0)));
    vq.push_back(mk_v("ld_rd0", 5'b10011, 64'h4008, 64'h0, 5'd0, 64'h1111, 0, 0,
                      mk_e(1, 0, 64'h4008, 8'hFF, 0, 64'h1111, 0, 0)));
    vq.push_back(mk_v("ld_u", 5'b10111, 64'h4010, 64'h0, 5'd4, 64'h8000_0000_0000_0001, 0, 0,
                      mk_e(1, 0, 64'h4010, 8'hFF, 0, 64'h8000_0000_0000_0001, 1, 0)));
    vq.push_back(mk_v("sb", 5'b11000, 64'h5007, 64'h1122_3344_5566_7788, 5'd6, 64'h0, 0, 0,
                      mk_e(1, 1, 64'h5007, 8'h80, 64'h8800_0000_0000_0000, 0, 0, 0)));
`ifdef MEM_MISALIGN_CHECK_EN
    vq.push_back(mk_v("lw_mis", 5'b10010, 64'h2002, 64'h0, 5'd10, 64'h1122_3344_5566_7788, 0, 1,
                      mk_e(0, 0, 0, 0, 0, 64'h2002, 0, 1)));
    vq.push_back(mk_v("sh_mis", 5'b11001, 64'h6001, 64'hBEEF, 5'd11, 64'h0, 0, 0,
                      mk_e(0, 0, 0, 0, 0, 64'h6001, 0, 1)));
`else
    vq.push_back(mk_v("lw_mis", 5'b10010, 64'h2002, 64'h0, 5'd10, 64'h1122_3344_5566_7788, 0, 1,
                      mk_e(1, 0, 64'h2000, 8'h0F, 0, 64'h5566_7788, 1, 0)));
    vq.push_back(mk_v("sh_mis", 5'b11001, 64'h6001, 64'hBEEF, 5'd11, 64'h0, 0, 0,
                      mk_e(1, 1, 64'h6000, 8'h03, 64'hBEEF, 0, 0, 0)));
`endif
    foreach (vq[i]) run_txn(vq[i]);

    reset_during(0, "rst_req");
    reset_during(1, "rst_wait");
    reset_during(2, "rst_done");

    for (int i = 0; i < 150; i++) begin
      logic [4:0] op;
      logic [63:0] addr, wdata, rdata;
      logic [4:0] rd;
      op    = 5'($urandom);
      op[4] = ($urandom_range(0, 4) != 0);
      addr  = {$urandom, $urandom};
      wdata = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      rd    = 5'($urandom);
      v = mk_v($sformatf("rnd%0d", i), op, addr, wdata, rd, rdata,
               $urandom_range(0, 3), $urandom_range(0, 3), model(op, addr, wdata, rd, rdata));
      run_txn(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
